// File: rtl/mac_rx_frame_dispatch.sv
// mac_rx_frame_dispatch: consumes the Ethernet header, qualifies dst MAC and EtherType,
// then passes the payload through to the ARP or IPv4 consumer or drops the frame.
module mac_rx_frame_dispatch #(
  parameter logic [15:0] ARP_TYPE  = 16'h0806,
  parameter logic [15:0] IP_TYPE   = 16'h0800,
  parameter int          HDR_BYTES = 14
) (
  input  logic        logic_clk,
  input  logic        logic_rst_n,
  input  logic [47:0] local_mac_in,
  input  logic [7:0]  mac_rdata_in,
  input  logic        mac_rvalid_in,
  output logic        mac_rready_out,
  input  logic        mac_rlast_in,
  output logic [7:0]  arp_tdata_out,
  output logic        arp_tvalid_out,
  input  logic        arp_tready_in,
  output logic        arp_tlast_out,
  output logic [7:0]  ip_tdata_out,
  output logic        ip_tvalid_out,
  input  logic        ip_tready_in,
  output logic        ip_tlast_out,
  output logic [47:0] frame_src_mac_out,
  output logic [15:0] frame_type_out,
  output logic [15:0] frame_cnt_out,
  output logic [15:0] drop_cnt_out
);
  typedef enum logic [1:0] {HDR, ARP, IP, DROP} state_t;
  state_t                     r_state;
  logic [3:0]                 r_hdr_cnt;
  logic [8*(HDR_BYTES-1)-1:0] r_hdr;
  logic [47:0]                r_src;
  logic [15:0]                r_type, r_frame_cnt, r_drop_cnt;
  logic [8*HDR_BYTES-1:0]     w_hdr;
  logic [47:0]                w_dst;
  logic [15:0]                w_type;
  logic                       w_acc, w_dst_ok, w_last_hdr, w_known, w_frame_inc, w_drop_inc;
  // The final header byte is still on the bus at decision time, so decode from the shifted view.
  assign w_hdr       = {r_hdr, mac_rdata_in};
  assign w_dst       = w_hdr[8*HDR_BYTES-1 -: 48];
  assign w_type      = w_hdr[15:0];
  assign w_acc       = mac_rvalid_in && mac_rready_out;
  assign w_dst_ok    = (w_dst == local_mac_in) || (w_dst == 48'hFFFF_FFFF_FFFF);
  assign w_known     = (w_type == ARP_TYPE) || (w_type == IP_TYPE);
  assign w_last_hdr  = r_hdr_cnt == 4'(HDR_BYTES-1);
  assign w_frame_inc = w_acc && !mac_rlast_in && r_state == HDR && w_last_hdr && w_dst_ok && w_known;
  assign w_drop_inc  = w_acc && mac_rlast_in && (r_state == HDR || r_state == DROP);
  assign mac_rready_out = r_state == ARP ? arp_tready_in : r_state == IP ? ip_tready_in : 1'b1;
  assign arp_tdata_out  = mac_rdata_in;
  assign arp_tvalid_out = r_state == ARP && mac_rvalid_in;
  assign arp_tlast_out  = r_state == ARP && mac_rlast_in;
  assign ip_tdata_out   = mac_rdata_in;
  assign ip_tvalid_out  = r_state == IP && mac_rvalid_in;
  assign ip_tlast_out   = r_state == IP && mac_rlast_in;
  assign frame_src_mac_out = r_src;
  assign frame_type_out    = r_type;
  assign frame_cnt_out     = r_frame_cnt;
  assign drop_cnt_out      = r_drop_cnt;
  always_ff @(posedge logic_clk or negedge logic_rst_n)
    if (!logic_rst_n) begin
      r_state     <= HDR;
      r_hdr_cnt   <= '0;
      r_hdr       <= '0;
      r_src       <= '0;
      r_type      <= '0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_frame_inc && r_frame_cnt != 16'hFFFF) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_drop_inc && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      if (w_frame_inc) begin
        r_src  <= w_hdr[63:16];
        r_type <= w_type;
      end
      if (w_acc)
        case (r_state)
          HDR: begin
            r_hdr     <= w_hdr[8*(HDR_BYTES-1)-1:0];
            r_hdr_cnt <= (mac_rlast_in || w_last_hdr) ? 4'd0 : r_hdr_cnt + 4'd1;
            if (!mac_rlast_in && w_last_hdr)
              r_state <= !w_dst_ok ? DROP : w_type == ARP_TYPE ? ARP : w_type == IP_TYPE ? IP : DROP;
          end
          default: if (mac_rlast_in) r_state <= HDR;
        endcase
    end
endmodule

// File: doc/mac_rx_frame_dispatch.md
Name: mac_rx_frame_dispatch

Overview:
- Sequences the received-frame stream from the MAC RX CRC/FIFO stage in the logic_clk domain.
- Frames arrive as CRC-checked, preamble-stripped bytes in AXI-stream style.
- Consumes the 14-byte Ethernet header, qualifies the destination MAC and decodes the EtherType.
- Routes the payload to the ARP consumer or the IPv4 consumer, or drops the frame. Keeps saturating frame and drop statistics.

Parameters:
- ARP_TYPE, 16'h0806, EtherType routed to the arp_* port.
- IP_TYPE, 16'h0800, EtherType routed to the ip_* port.
- HDR_BYTES, 14, header length in bytes: dst[6], src[6], type[2].

Ports:
- logic_clk  in  1  system logic clock.
- logic_rst_n  in  1  asynchronous active-low reset.
- local_mac_in  in  48  station MAC, byte 0 in [47:40]; quasi-static.
- mac_rdata_in  in  8  received byte.
- mac_rvalid_in  in  1  byte valid.
- mac_rready_out  out  1  byte accepted when valid && ready.
- mac_rlast_in  in  1  last byte of frame.
- arp_tdata_out  out  8  ARP payload byte.
- arp_tvalid_out  out  1  ARP payload valid.
- arp_tready_in  in  1  ARP consumer ready.
- arp_tlast_out  out  1  ARP payload last.
- ip_tdata_out  out  8  IPv4 payload byte.
- ip_tvalid_out  out  1  IPv4 payload valid.
- ip_tready_in  in  1  IPv4 consumer ready.
- ip_tlast_out  out  1  IPv4 payload last.
- frame_src_mac_out  out  48  source MAC of the current or last routed frame.
- frame_type_out  out  16  EtherType of the current or last routed frame.
- frame_cnt_out  out  16  routed-frame count, saturating.
- drop_cnt_out  out  16  dropped-frame count, saturating.

Behaviour:

States: HDR, ARP, IP, DROP.
- Reset (logic_rst_n=0, async) forces HDR with hdr_cnt=0.
- All capture registers, frame_src_mac_out, frame_type_out and both counters reset to 0.
- No resync after reset: the first accepted byte is header byte 0.

HDR:
- mac_rready_out=1; both tvalid outputs 0.
- Each accepted byte is stored in a 14-byte shift/capture register and hdr_cnt increments (4 bits).
- Accepted byte with mac_rlast_in=1 at hdr_cnt<=13 (runt, including a 14-byte frame with no payload): drop_cnt_out++, hdr_cnt=0, stay in HDR.
- Decision on acceptance of byte 13 with rlast=0:
  - dst_ok = (dst==local_mac_in) || (dst==48'hFFFF_FFFF_FFFF).
  - dst_ok && type==ARP_TYPE -> ARP.
  - dst_ok && type==IP_TYPE -> IP.
  - Otherwise -> DROP.
- On the transition to ARP or IP: frame_src_mac_out and frame_type_out load from the header (registered, valid from the next cycle) and frame_cnt_out++.
- hdr_cnt clears on any exit from HDR.

ARP / IP:
- Zero-latency combinational passthrough to the selected port:
  - x_tdata_out = mac_rdata_in.
  - x_tvalid_out = mac_rvalid_in.
  - x_tlast_out = mac_rlast_in.
  - mac_rready_out = x_tready_in.
- The other port's tvalid and tlast stay 0; tdata is don't-care but driven with mac_rdata_in.
- Accepted byte with rlast=1 -> HDR.
- Backpressure: a stalled consumer holds mac_rready_out=0. Upstream must hold data stable.

DROP:
- mac_rready_out=1; discard bytes.
- Accepted rlast -> drop_cnt_out++, go to HDR.

Counters:
- 16-bit; hold at 16'hFFFF, no wrap.
- Increment at most once per cycle.
- A frame counts in exactly one counter. A DROP frame counts at its rlast, not at the decision.

Boundary conditions:
- mac_rvalid_in=0 gaps are allowed anywhere; state and hdr_cnt hold.
- local_mac_in changes mid-header: the compare uses the value at the byte-13 acceptance cycle.
- Async reset mid-payload: outputs deassert immediately; the partial frame is lost and not counted.

Test Plan:
1. Broadcast dst FF..FF, src 00:11:22:33:44:55, type 0806, 28-byte payload, readies=1 -> 28 beats on arp_*, tlast on beat 28; frame_src_mac_out=48'h001122334455; frame_type_out=16'h0806; frame_cnt_out=1; drop_cnt_out=0.
2. dst=local_mac_in=02:00:00:00:00:01, type 0800, 46-byte payload; ip_tready_in toggles 1,0 each cycle -> all 46 bytes on ip_* in order, no loss; mac_rready_out mirrors ip_tready_in; arp_tvalid_out never 1.
3. dst 02:00:00:00:00:99 (mismatch), type 0800, 60 bytes; then type 86DD to the local MAC, 40 bytes -> no output beats; drop_cnt_out=2; frame_cnt_out unchanged.
4. Runt of 10 bytes with rlast, then a valid ARP frame -> drop_cnt_out=1; the ARP frame routes correctly (hdr_cnt restarted at 0).
5. Assert logic_rst_n=0 for 1 cycle at payload byte 5 of an IP frame -> ip_tvalid_out=0 immediately; counters=0; the next frame sent from byte 0 routes normally.
6. Preload 65535 drops (force/fast path), then 2 more dropped frames -> drop_cnt_out holds 16'hFFFF.
